lsu_dcache_master: RTL

- Load/store unit back end: the initiating side of the dcache cmd/rsp interface that the simulation memory wrapper answers.
- Takes one memory request at a time from the execute stage and checks natural alignment.
- Issues an 8-byte-aligned dcache command with byte strobes, waits for the read response, and returns shifted, sign- or zero-extended load data.
- Stores complete on command handshake; the memory side returns no response for writes.

---
 rtl/lsu_dcache_master.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/lsu_dcache_master.sv
// ============================================================================
//  Module   : lsu_dcache_master
//  Brief    : LSU back end. Takes one execute-stage memory request at a time,
//             checks natural alignment, issues an 8-byte-aligned dcache
//             command with byte strobes and returns extended load data.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_dcache_master #(
  parameter int RSP_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        dcache_cmd_valid,
  input  logic        dcache_cmd_ready,
  output logic [63:0] dcache_cmd_payload_addr,
  output logic        dcache_cmd_payload_wen,
  output logic [63:0] dcache_cmd_payload_wdata,
  output logic [7:0]  dcache_cmd_payload_wstrb,
  output logic [2:0]  dcache_cmd_payload_size,
  input  logic        dcache_rsp_valid,
  input  logic [63:0] dcache_rsp_payload_data,
  output logic        done_valid,
  output logic [63:0] done_data,
  output logic [1:0]  done_err
);

  // Counter only needs to reach RSP_TIMEOUT-1; keep at least one bit.
  localparam int                 c_CNT_W      = (RSP_TIMEOUT > 1) ? $clog2(RSP_TIMEOUT) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST   = c_CNT_W'((RSP_TIMEOUT > 0) ? RSP_TIMEOUT - 1 : 0);
  localparam bit                 c_TIMEOUT_EN = (RSP_TIMEOUT != 0);

  localparam logic [1:0] c_ERR_OK       = 2'd0;
  localparam logic [1:0] c_ERR_MISALIGN = 2'd1;
  localparam logic [1:0] c_ERR_TIMEOUT  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_CMD      = 2'd1,
    S_WAIT_RSP = 2'd2
  } state_t;

  state_t             r_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_wen;
  logic [2:0]         r_off;
  logic [1:0]         r_size;
  logic               r_unsigned;

  logic               r_req_ready;
  logic               r_cmd_valid;
  logic [63:0]        r_cmd_addr;
  logic               r_cmd_wen;
  logic [63:0]        r_cmd_wdata;
  logic [7:0]         r_cmd_wstrb;
  logic [2:0]         r_cmd_size;
  logic               r_done_valid;
  logic [63:0]        r_done_data;
  logic [1:0]         r_done_err;

  logic               w_misaligned;
  logic [7:0]         w_strb_base;
  logic [7:0]         w_cmd_wstrb;
  logic [63:0]        w_cmd_wdata;
  logic [63:0]        w_rsp_shift;
  logic [63:0]        w_load_data;

  // Alignment check and lane placement of the incoming request.
  always_comb begin
    w_misaligned = 1'b0;
    w_strb_base  = 8'h01;
    case (req_size)
      2'd0: begin w_misaligned = 1'b0;              w_strb_base = 8'h01; end
      2'd1: begin w_misaligned = req_addr[0];       w_strb_base = 8'h03; end
      2'd2: begin w_misaligned = |req_addr[1:0];    w_strb_base = 8'h0F; end
      default: begin w_misaligned = |req_addr[2:0]; w_strb_base = 8'hFF; end
    endcase
    w_cmd_wstrb = w_strb_base << req_addr[2:0];
    w_cmd_wdata = req_wdata << {req_addr[2:0], 3'b000};
  end

  // Extract the addressed bytes from the aligned response and extend them.
  always_comb begin
    w_rsp_shift = dcache_rsp_payload_data >> {r_off, 3'b000};
    w_load_data = w_rsp_shift;
    case (r_size)
      2'd0: w_load_data = r_unsigned ? {56'd0, w_rsp_shift[7:0]}
                                     : {{56{w_rsp_shift[7]}}, w_rsp_shift[7:0]};
      2'd1: w_load_data = r_unsigned ? {48'd0, w_rsp_shift[15:0]}
                                     : {{48{w_rsp_shift[15]}}, w_rsp_shift[15:0]};
      2'd2: w_load_data = r_unsigned ? {32'd0, w_rsp_shift[31:0]}
                                     : {{32{w_rsp_shift[31]}}, w_rsp_shift[31:0]};
      default: w_load_data = w_rsp_shift;
    endcase
  end

  // Request FSM with registered handshake, command and completion outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_wen        <= 1'b0;
      r_off        <= 3'd0;
      r_size       <= 2'd0;
      r_unsigned   <= 1'b0;
      r_req_ready  <= 1'b1;
      r_cmd_valid  <= 1'b0;
      r_cmd_addr   <= 64'd0;
      r_cmd_wen    <= 1'b0;
      r_cmd_wdata  <= 64'd0;
      r_cmd_wstrb  <= 8'd0;
      r_cmd_size   <= 3'd0;
      r_done_valid <= 1'b0;
      r_done_data  <= 64'd0;
      r_done_err   <= c_ERR_OK;
    end else begin
      r_done_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            if (w_misaligned) begin
              // Rejected without touching the dcache; stay ready.
              r_done_valid <= 1'b1;
              r_done_err   <= c_ERR_MISALIGN;
              r_done_data  <= 64'd0;
            end else begin
              r_wen       <= req_wen;
              r_off       <= req_addr[2:0];
              r_size      <= req_size;
              r_unsigned  <= req_unsigned;
              r_cmd_valid <= 1'b1;
              r_cmd_addr  <= {req_addr[63:3], 3'b000};
              r_cmd_wen   <= req_wen;
              r_cmd_wdata <= w_cmd_wdata;
              r_cmd_wstrb <= w_cmd_wstrb;
              r_cmd_size  <= {1'b0, req_size};
              r_req_ready <= 1'b0;
              r_state     <= S_CMD;
            end
          end
        end
        S_CMD: begin
          if (dcache_cmd_ready) begin
            r_cmd_valid <= 1'b0;
            if (r_wen) begin
              // Stores finish on the handshake; no write response exists.
              r_done_valid <= 1'b1;
              r_done_err   <= c_ERR_OK;
              r_done_data  <= 64'd0;
              r_req_ready  <= 1'b1;
              r_state      <= S_IDLE;
            end else begin
              r_cnt   <= '0;
              r_state <= S_WAIT_RSP;
            end
          end
        end
        S_WAIT_RSP: begin
          if (dcache_rsp_valid) begin
            r_done_valid <= 1'b1;
            r_done_err   <= c_ERR_OK;
            r_done_data  <= w_load_data;
            r_req_ready  <= 1'b1;
            r_state      <= S_IDLE;
          end else if (c_TIMEOUT_EN && (r_cnt == c_CNT_LAST)) begin
            r_done_valid <= 1'b1;
            r_done_err   <= c_ERR_TIMEOUT;
            r_done_data  <= 64'd0;
            r_req_ready  <= 1'b1;
            r_state      <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_req_ready <= 1'b1;
          r_cmd_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready                = r_req_ready;
  assign dcache_cmd_valid         = r_cmd_valid;
  assign dcache_cmd_payload_addr  = r_cmd_addr;
  assign dcache_cmd_payload_wen   = r_cmd_wen;
  assign dcache_cmd_payload_wdata = r_cmd_wdata;
  assign dcache_cmd_payload_wstrb = r_cmd_wstrb;
  assign dcache_cmd_payload_size  = r_cmd_size;
  assign done_valid               = r_done_valid;
  assign done_data                = r_done_data;
  assign done_err                 = r_done_err;

endmodule

`default_nettype wire
